// File: rtl/sdram_device_responder.sv
// 16-bit SDR SDRAM device model: per-bank open/close tracking, byte-masked storage,
// CAS-latency read pipeline, and sticky protocol/timing/bus-contention flags.
module sdram_device_responder #(
  parameter int ROW_BITS    = 12,
  parameter int COL_BITS    = 10,
  parameter int CAS_LATENCY = 2,
  parameter int TRCD        = 2,
  parameter int TRP         = 2,
  parameter int MEM_AW      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sd_cmd,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_in,
  input  logic        sd_dq_oe,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_out_en,
  output logic [3:0]  bank_active,
  output logic        err_protocol,
  output logic        err_timing,
  output logic        err_bus
);

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_NOP = 3'b111;

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW   = $clog2(TMAX + 1) + 1;
  localparam int LAST = CAS_LATENCY - 2;
  localparam int FW   = 2 + ROW_BITS + COL_BITS;

  typedef enum logic {B_IDLE, B_ACTIVE} bank_state_e;

  bank_state_e             state_q [4];
  logic [ROW_BITS-1:0]     row_q   [4];
  // Counters hold the clock distance since the bank's last ACT / precharge edge.
  logic [CW-1:0]           trcd_q  [4];
  logic [CW-1:0]           trp_q   [4];
  logic [LAST:0]           vld_pipe_q;
  logic [1:0]              dqm_pipe_q [CAS_LATENCY-1];
  logic [15:0]             dat_pipe_q [CAS_LATENCY-1];
  logic [15:0]             dq_out_q;
  logic                    dq_out_en_q;
  logic                    err_protocol_q, err_timing_q, err_bus_q;
  logic [15:0]             mem [2**MEM_AW];

  logic                    is_act, is_rd, is_wr, is_pre, is_bad;
  logic                    bank_open, rd_fire, wr_fire;
  logic [FW-1:0]           word_full;
  logic [MEM_AW-1:0]       mem_addr;
  logic [15:0]             rd_mask_d;
  logic                    unused_bits;

  always_comb begin
    is_act    = (sd_cmd == CMD_ACT);
    is_rd     = (sd_cmd == CMD_RD);
    is_wr     = (sd_cmd == CMD_WR);
    is_pre    = (sd_cmd == CMD_PRE);
    is_bad    = !(is_act || is_rd || is_wr || is_pre || sd_cmd == CMD_NOP);
    bank_open = (state_q[sd_ba] == B_ACTIVE);
    rd_fire   = is_rd && bank_open && !rst;
    wr_fire   = is_wr && bank_open && !rst;
    word_full = {sd_ba, row_q[sd_ba], sd_a[COL_BITS-1:0]};
    mem_addr  = word_full[MEM_AW-1:0];
    rd_mask_d = {dqm_pipe_q[LAST][1] ? 8'h00 : dat_pipe_q[LAST][15:8],
                 dqm_pipe_q[LAST][0] ? 8'h00 : dat_pipe_q[LAST][7:0]};
  end

  assign unused_bits = ^{sd_a, word_full};

  // Storage and read data path carry no reset so memory survives rst.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (!sd_dqm[0]) mem[mem_addr][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqm[1]) mem[mem_addr][15:8] <= sd_dq_in[15:8];
    end
    dat_pipe_q[0] <= mem[mem_addr];
    for (int i = 1; i < CAS_LATENCY - 1; i++) dat_pipe_q[i] <= dat_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        state_q[b] <= B_IDLE;
        row_q[b]   <= '0;
        trcd_q[b]  <= '1;
        trp_q[b]   <= '1;
      end
      for (int i = 0; i < CAS_LATENCY - 1; i++) dqm_pipe_q[i] <= '0;
      vld_pipe_q     <= '0;
      dq_out_q       <= '0;
      dq_out_en_q    <= 1'b0;
      err_protocol_q <= 1'b0;
      err_timing_q   <= 1'b0;
      err_bus_q      <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (trcd_q[b] != '1) trcd_q[b] <= trcd_q[b] + 1'b1;
        if (trp_q[b]  != '1) trp_q[b]  <= trp_q[b]  + 1'b1;
      end

      if (is_bad) err_protocol_q <= 1'b1;

      if (is_act) begin
        if (bank_open) err_protocol_q <= 1'b1;
        if (trp_q[sd_ba] < CW'(TRP)) err_timing_q <= 1'b1;
        state_q[sd_ba] <= B_ACTIVE;
        row_q[sd_ba]   <= sd_a[ROW_BITS-1:0];
        trcd_q[sd_ba]  <= CW'(1);
      end

      if (is_rd || is_wr) begin
        if (!bank_open) begin
          err_protocol_q <= 1'b1;
        end else begin
          if (trcd_q[sd_ba] < CW'(TRCD)) err_timing_q <= 1'b1;
          if (sd_a[10]) begin
            state_q[sd_ba] <= B_IDLE;
            trp_q[sd_ba]   <= CW'(1);
          end
        end
      end

      if (is_pre) begin
        for (int b = 0; b < 4; b++) begin
          if (sd_a[10] || sd_ba == 2'(b)) begin
            state_q[b] <= B_IDLE;
            trp_q[b]   <= CW'(1);
          end
        end
      end

      vld_pipe_q[0] <= rd_fire;
      dqm_pipe_q[0] <= sd_dqm;
      for (int i = 1; i < CAS_LATENCY - 1; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        dqm_pipe_q[i] <= dqm_pipe_q[i-1];
      end

      dq_out_en_q <= vld_pipe_q[LAST];
      dq_out_q    <= vld_pipe_q[LAST] ? rd_mask_d : 16'h0000;

      if (sd_dq_oe && dq_out_en_q) err_bus_q <= 1'b1;
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) bank_active[b] = (state_q[b] == B_ACTIVE);
  end

  assign sd_dq_out    = dq_out_q;
  assign sd_dq_out_en = dq_out_en_q;
  assign err_protocol = err_protocol_q;
  assign err_timing   = err_timing_q;
  assign err_bus      = err_bus_q;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder (CL=2, TRCD=2, TRP=2, MEM_AW=12).
module tb_sdram_device_responder;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sd_cmd;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_in;
  logic        sd_dq_oe;
  logic [15:0] sd_dq_out;
  logic        sd_dq_out_en;
  logic [3:0]  bank_active;
  logic        err_protocol, err_timing, err_bus;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_device_responder #(
    .ROW_BITS(12), .COL_BITS(10), .CAS_LATENCY(2), .TRCD(2), .TRP(2), .MEM_AW(12)
  ) dut (
    .clk(clk), .rst(rst), .sd_cmd(sd_cmd), .sd_ba(sd_ba), .sd_a(sd_a),
    .sd_dqm(sd_dqm), .sd_dq_in(sd_dq_in), .sd_dq_oe(sd_dq_oe),
    .sd_dq_out(sd_dq_out), .sd_dq_out_en(sd_dq_out_en), .bank_active(bank_active),
    .err_protocol(err_protocol), .err_timing(err_timing), .err_bus(err_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] dq);
    sd_cmd = c; sd_ba = ba; sd_a = a; sd_dqm = dqm; sd_dq_in = dq;
    sd_dq_oe = (c == C_WR);
    step(1);
    sd_cmd = C_NOP; sd_ba = 2'd0; sd_a = 13'd0; sd_dqm = 2'b00; sd_dq_in = 16'h0000;
    sd_dq_oe = 1'b0;
  endtask

  // Call right after a READ edge: data must appear exactly one cycle later, for one cycle.
  task automatic read_back(input string tag, input logic [15:0] exp);
    check({tag, "_en_early"}, {31'd0, sd_dq_out_en}, 32'd0);
    step(1);
    check({tag, "_en"}, {31'd0, sd_dq_out_en}, 32'd1);
    check({tag, "_data"}, {16'd0, sd_dq_out}, {16'd0, exp});
    step(1);
    check({tag, "_en_late"}, {31'd0, sd_dq_out_en}, 32'd0);
  endtask

  task automatic check_errs(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, err_protocol, err_timing, err_bus}, {29'd0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sd_cmd = C_NOP; sd_ba = 2'd0; sd_a = 13'd0; sd_dqm = 2'b00;
    sd_dq_in = 16'h0000; sd_dq_oe = 1'b0;
    do_reset();

    // Reset state
    check("rst_en", {31'd0, sd_dq_out_en}, 32'd0);
    check("rst_dq", {16'd0, sd_dq_out}, 32'd0);
    check("rst_banks", {28'd0, bank_active}, 32'd0);
    check_errs("rst_errs", 3'b000);

    // 1. write then read with auto-precharge
    issue(C_ACT, 2'd0, 13'h0005, 2'b00, 16'h0000);
    check("t1_act_bank", {28'd0, bank_active}, 32'h1);
    step(1);
    issue(C_WR, 2'd0, 13'h0412, 2'b00, 16'hBEEF);
    check("t1_wr_close", {28'd0, bank_active}, 32'h0);
    step(5);
    issue(C_ACT, 2'd0, 13'h0005, 2'b00, 16'h0000);
    step(1);
    issue(C_RD, 2'd0, 13'h0412, 2'b00, 16'h0000);
    check("t1_rd_close", {28'd0, bank_active}, 32'h0);
    read_back("t1_rd", 16'hBEEF);
    check_errs("t1_errs", 3'b000);

    // 2. byte masks
    step(1);
    issue(C_ACT, 2'd0, 13'h0005, 2'b00, 16'h0000);
    step(1);
    issue(C_WR, 2'd0, 13'h0020, 2'b00, 16'h1234);
    issue(C_WR, 2'd0, 13'h0020, 2'b10, 16'hABCD);
    issue(C_RD, 2'd0, 13'h0420, 2'b01, 16'h0000);
    read_back("t2_rd_masked", 16'h1200);
    issue(C_ACT, 2'd0, 13'h0005, 2'b00, 16'h0000);
    step(1);
    issue(C_RD, 2'd0, 13'h0420, 2'b00, 16'h0000);
    read_back("t2_rd_store", 16'h12CD);

    // 3. interleaved banks 0/1
    issue(C_ACT, 2'd0, 13'h0001, 2'b00, 16'h0000);
    issue(C_ACT, 2'd1, 13'h0001, 2'b00, 16'h0000);
    check("t3_banks_open", {28'd0, bank_active}, 32'h3);
    for (int k = 0; k < 4; k++)
      issue(C_WR, 2'(k % 2), 13'(k), 2'b00, 16'(16'h00A0 + k));
    issue(C_RD, 2'd0, 13'h0000, 2'b00, 16'h0000);
    issue(C_RD, 2'd1, 13'h0001, 2'b00, 16'h0000);
    check("t3_r0_en", {31'd0, sd_dq_out_en}, 32'd1);
    check("t3_r0", {16'd0, sd_dq_out}, 32'h00A0);
    issue(C_RD, 2'd0, 13'h0402, 2'b00, 16'h0000);
    check("t3_r1_en", {31'd0, sd_dq_out_en}, 32'd1);
    check("t3_r1", {16'd0, sd_dq_out}, 32'h00A1);
    issue(C_RD, 2'd1, 13'h0403, 2'b00, 16'h0000);
    check("t3_r2_en", {31'd0, sd_dq_out_en}, 32'd1);
    check("t3_r2", {16'd0, sd_dq_out}, 32'h00A2);
    step(1);
    check("t3_r3_en", {31'd0, sd_dq_out_en}, 32'd1);
    check("t3_r3", {16'd0, sd_dq_out}, 32'h00A3);
    step(1);
    check("t3_done_en", {31'd0, sd_dq_out_en}, 32'd0);
    check("t3_banks_closed", {28'd0, bank_active}, 32'h0);
    check_errs("t3_errs", 3'b000);

    // 4. protocol errors
    issue(C_RD, 2'd2, 13'h0000, 2'b00, 16'h0000);
    check_errs("t4_rd_idle_errs", 3'b100);
    check("t4_rd_idle_en0", {31'd0, sd_dq_out_en}, 32'd0);
    step(1);
    check("t4_rd_idle_en1", {31'd0, sd_dq_out_en}, 32'd0);
    step(1);
    issue(C_ACT, 2'd1, 13'h0002, 2'b00, 16'h0000);
    step(2);
    issue(C_ACT, 2'd1, 13'h0002, 2'b00, 16'h0000);
    check("t4_dbl_act_bank", {28'd0, bank_active}, 32'h2);
    check_errs("t4_dbl_act_errs", 3'b100);
    issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0000);
    check("t4_pre_all", {28'd0, bank_active}, 32'h0);

    // 5a. tRCD violation, data still returned
    do_reset();
    check_errs("t5_rst_errs", 3'b000);
    issue(C_ACT, 2'd0, 13'h0003, 2'b00, 16'h0000);
    step(1);
    issue(C_WR, 2'd0, 13'h0405, 2'b00, 16'h5A5A);
    step(1);
    issue(C_ACT, 2'd0, 13'h0003, 2'b00, 16'h0000);
    check_errs("t5_pre_viol", 3'b000);
    issue(C_RD, 2'd0, 13'h0005, 2'b00, 16'h0000);
    check_errs("t5_trcd_errs", 3'b010);
    check("t5_trcd_bank", {28'd0, bank_active}, 32'h1);
    read_back("t5_trcd_rd", 16'h5A5A);

    // 5b. tRP violation after auto-precharge
    do_reset();
    issue(C_ACT, 2'd0, 13'h0003, 2'b00, 16'h0000);
    step(1);
    issue(C_WR, 2'd0, 13'h0405, 2'b11, 16'hFFFF);
    check_errs("t5_trp_before", 3'b000);
    issue(C_ACT, 2'd0, 13'h0003, 2'b00, 16'h0000);
    check_errs("t5_trp_errs", 3'b010);
    check("t5_trp_bank", {28'd0, bank_active}, 32'h1);

    // 6a. bus contention during read data cycle
    step(1);
    issue(C_RD, 2'd0, 13'h0405, 2'b00, 16'h0000);
    step(1);
    check("t6_bus_en", {31'd0, sd_dq_out_en}, 32'd1);
    check("t6_bus_data", {16'd0, sd_dq_out}, 32'h5A5A);
    sd_dq_oe = 1'b1;
    step(1);
    sd_dq_oe = 1'b0;
    check_errs("t6_bus_errs", 3'b011);

    // 6b. reset the cycle after a READ drops the read
    step(1);
    issue(C_ACT, 2'd0, 13'h0003, 2'b00, 16'h0000);
    step(1);
    issue(C_RD, 2'd0, 13'h0005, 2'b00, 16'h0000);
    rst = 1'b1;
    step(1);
    check("t6_rst_en0", {31'd0, sd_dq_out_en}, 32'd0);
    rst = 1'b0;
    step(1);
    check("t6_rst_en1", {31'd0, sd_dq_out_en}, 32'd0);
    check_errs("t6_rst_errs", 3'b000);
    check("t6_rst_banks", {28'd0, bank_active}, 32'h0);

    // Memory retained across reset
    issue(C_ACT, 2'd0, 13'h0003, 2'b00, 16'h0000);
    step(1);
    issue(C_RD, 2'd0, 13'h0405, 2'b00, 16'h0000);
    read_back("t6_retain", 16'h5A5A);
    check_errs("t6_final_errs", 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
